// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the two requester ports (instruction fetch, data load/store) and
//   the Avalon-style memory master port that mem_arbiter sequences.
//
//   Handshake semantics:
//     * i_req / d_req are levels. A requester raises req with its address
//       (and data fields) and holds req until it sees the matching one-cycle
//       *_ack. *_rdata / *_err are meaningful only while *_ack is high, and
//       read as zero otherwise. A req still high after its ack is treated as
//       a fresh request.
//     * mem_read / mem_write are valid strobes. The bus address, write data
//       and byte enables are held constant while the slave keeps
//       mem_waitrequest high. A transfer completes in the cycle where a
//       strobe is high and mem_waitrequest is low. mem_readdata is sampled
//       in that cycle.
//
//   Modports:
//     master - the arbiter: it consumes requests and masters the memory bus.
//     slave  - the environment: the requesters plus the memory slave.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Instruction fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  // Data load/store requester
  logic              d_req;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_byteen;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  // Memory master port
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_read;
  logic              mem_write;
  logic              mem_waitrequest;
  logic [DATA_W-1:0] mem_readdata;

  modport master (
    input  i_req, i_addr,
    output i_ack, i_rdata, i_err,
    input  d_req, d_write, d_addr, d_wdata, d_byteen,
    output d_ack, d_rdata, d_err,
    output mem_address, mem_writedata, mem_byteenable, mem_read, mem_write,
    input  mem_waitrequest, mem_readdata
  );

  modport slave (
    output i_req, i_addr,
    input  i_ack, i_rdata, i_err,
    output d_req, d_write, d_addr, d_wdata, d_byteen,
    input  d_ack, d_rdata, d_err,
    input  mem_address, mem_writedata, mem_byteenable, mem_read, mem_write,
    output mem_waitrequest, mem_readdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one Avalon-style memory master port between instruction fetch and
//   data load/store. One request is latched at a time, the bus is held stable
//   across mem_waitrequest, and completion is returned as a one-cycle ack.
//   A stall that lasts longer than TIMEOUT cycles is aborted and reported
//   through *_err.
//
//   Parameters: ADDR_W, DATA_W (byte enables = DATA_W/8), TIMEOUT (0 = off)
//   Ports:
//     clk         - clock, rising edge
//     reset       - asynchronous, active-low reset
//     bus         - mem_arbiter_if.master: requester ports + memory port
//     busy        - high whenever the FSM is not IDLE
//     o_dbg_state - current FSM state (0 IDLE, 1 ISSUE, 2 RESP)
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_arbiter_if.master        bus,
  output logic                 busy,
  output logic [1:0]           o_dbg_state
);
  localparam int BE_W  = DATA_W / 8;
  // One spare bit keeps the counter legal when the timeout is disabled.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last_grant;  // 1 = data was granted last
  logic              r_grant_d;     // current transfer belongs to data port
  logic [CNT_W-1:0]  r_stall;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_byteen;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_i_ack;
  logic              r_i_err;
  logic [DATA_W-1:0] r_i_rdata;
  logic              r_d_ack;
  logic              r_d_err;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_pick_d;
  logic              w_timeout;
  logic              w_stall_max;
  logic              w_store;
  logic [DATA_W-1:0] w_rd_cap;

  // Data wins when it is the only requester, or on contention when fetch
  // was served last.
  assign w_pick_d    = bus.d_req && (!bus.i_req || !r_last_grant);
  assign w_store     = w_pick_d && bus.d_write;
  assign w_timeout   = (TIMEOUT != 0) && (r_stall >= CNT_W'(TIMEOUT));
  assign w_stall_max = &r_stall;
  assign w_rd_cap    = r_mem_read ? bus.mem_readdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant_d    <= 1'b0;
      r_stall      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_byteen     <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_i_ack      <= 1'b0;
      r_i_err      <= 1'b0;
      r_i_rdata    <= '0;
      r_d_ack      <= 1'b0;
      r_d_err      <= 1'b0;
      r_d_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_req || bus.d_req) begin
            r_grant_d   <= w_pick_d;
            r_addr      <= w_pick_d ? bus.d_addr : bus.i_addr;
            r_wdata     <= w_store ? bus.d_wdata : '0;
            r_byteen    <= w_pick_d ? bus.d_byteen : '1;
            r_mem_read  <= !w_store;
            r_mem_write <= w_store;
            r_stall     <= '0;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A completing cycle wins over the timeout check.
          if (!bus.mem_waitrequest) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_i_ack     <= !r_grant_d;
            r_d_ack     <= r_grant_d;
            r_i_rdata   <= r_grant_d ? '0 : w_rd_cap;
            r_d_rdata   <= r_grant_d ? w_rd_cap : '0;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_i_ack     <= !r_grant_d;
            r_d_ack     <= r_grant_d;
            r_i_err     <= !r_grant_d;
            r_d_err     <= r_grant_d;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_state     <= S_RESP;
          end else if (!w_stall_max) begin
            r_stall <= r_stall + CNT_W'(1);
          end
        end
        S_RESP: begin
          r_i_ack      <= 1'b0;
          r_i_err      <= 1'b0;
          r_i_rdata    <= '0;
          r_d_ack      <= 1'b0;
          r_d_err      <= 1'b0;
          r_d_rdata    <= '0;
          r_last_grant <= r_grant_d;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_address    = r_addr;
  assign bus.mem_writedata  = r_wdata;
  assign bus.mem_byteenable = r_byteen;
  assign bus.mem_read       = r_mem_read;
  assign bus.mem_write      = r_mem_write;
  assign bus.i_ack          = r_i_ack;
  assign bus.i_err          = r_i_err;
  assign bus.i_rdata        = r_i_rdata;
  assign bus.d_ack          = r_d_ack;
  assign bus.d_err          = r_d_err;
  assign bus.d_rdata        = r_d_rdata;

  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Bench for mem_arbiter with TIMEOUT = 4. A memory slave process answers
//   each transfer after a planned number of stall cycles and returns a
//   value derived from the address. A monitor turns every completion into a
//   transaction record; a reference model predicts the record from the
//   requests issued and the stall plan.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  typedef struct packed {
    logic        who_d;
    logic        wr;
    logic        err;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  ncyc;
    logic        stable;
    logic        aligned;
  } txn_t;
  localparam int TW = $bits(txn_t);

  logic clk;
  logic reset;
  logic busy;
  logic [1:0] dbg_state;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] obs_q[$];

  // Slave behaviour knobs
  int          stall_plan = 0;
  logic        use_fixed  = 1'b0;
  logic [31:0] fixed_rd   = '0;
  logic        model_last_d = 1'b1;  // arbitration history, 1 = data last

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] mem_value(input logic [31:0] a);
    return use_fixed ? fixed_rd : (a ^ 32'hA5A5_5A5A);
  endfunction

  function automatic txn_t model_txn(input logic who_d, input logic wr,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [3:0] be, input int stall);
    txn_t t;
    logic is_wr;
    is_wr   = who_d & wr;
    t       = '0;
    t.who_d = who_d;
    t.wr    = is_wr;
    t.be    = who_d ? be : 4'hF;
    t.addr  = addr;
    t.wdata = is_wr ? wdata : 32'h0;
    if (TO != 0 && stall > TO) begin
      t.err   = 1'b1;
      t.rdata = 32'h0;
      t.ncyc  = 8'(TO + 1);
    end else begin
      t.err   = 1'b0;
      t.rdata = is_wr ? 32'h0 : mem_value(addr);
      t.ncyc  = 8'(stall + 1);
    end
    t.stable  = 1'b1;
    t.aligned = 1'b1;
    return t;
  endfunction

  // ---------------- memory slave ----------------
  int   stall_left = 0;
  logic rsp_prev   = 1'b0;
  always @(negedge clk) begin
    if (bus.mem_read || bus.mem_write) begin
      if (!rsp_prev) stall_left = stall_plan;
      if (stall_left > 0) begin
        bus.mem_waitrequest = 1'b1;
        stall_left--;
      end else begin
        bus.mem_waitrequest = 1'b0;
      end
      rsp_prev = 1'b1;
    end else begin
      bus.mem_waitrequest = 1'b0;
      rsp_prev = 1'b0;
    end
    bus.mem_readdata = mem_value(bus.mem_address);
  end

  // ---------------- monitor ----------------
  txn_t mon_cur;
  logic mon_in_xfer = 1'b0;
  logic mon_prev_strobe = 1'b0;
  logic mon_prev_ack = 1'b0;
  logic mon_strobe;
  always @(negedge clk) begin
    mon_strobe = bus.mem_read | bus.mem_write;
    if (!reset) begin
      mon_in_xfer = 1'b0;
      mon_strobe  = 1'b0;
    end else begin
      if (mon_strobe) begin
        if (!mon_in_xfer) begin
          mon_in_xfer    = 1'b1;
          mon_cur        = '0;
          mon_cur.addr   = bus.mem_address;
          mon_cur.wr     = bus.mem_write;
          mon_cur.be     = bus.mem_byteenable;
          mon_cur.wdata  = bus.mem_write ? bus.mem_writedata : 32'h0;
          mon_cur.stable = 1'b1;
        end else if (bus.mem_address !== mon_cur.addr || bus.mem_write !== mon_cur.wr ||
                     bus.mem_byteenable !== mon_cur.be ||
                     (bus.mem_write && bus.mem_writedata !== mon_cur.wdata)) begin
          mon_cur.stable = 1'b0;
        end
        mon_cur.ncyc = mon_cur.ncyc + 8'd1;
      end
      if (bus.i_ack || bus.d_ack) begin
        mon_cur.who_d   = bus.d_ack;
        mon_cur.err     = bus.d_ack ? bus.d_err : bus.i_err;
        mon_cur.rdata   = bus.d_ack ? bus.d_rdata : bus.i_rdata;
        mon_cur.aligned = mon_in_xfer && mon_prev_strobe && !mon_strobe;
        obs_q.push_back(mon_cur);
        mon_in_xfer = 1'b0;
      end
    end
    // Idle outputs are zero, acks are single pulses, strobes exclusive.
    n_vec++;
    if ((!bus.i_ack && (bus.i_rdata !== 32'h0 || bus.i_err !== 1'b0)) ||
        (!bus.d_ack && (bus.d_rdata !== 32'h0 || bus.d_err !== 1'b0)) ||
        (bus.mem_read && bus.mem_write) || (bus.i_ack && bus.d_ack) ||
        ((bus.i_ack || bus.d_ack) && mon_prev_ack)) begin
      n_err++;
      $display("FAIL bus_rules @%0t: i_ack=%b i_rdata=%h i_err=%b d_ack=%b d_rdata=%h d_err=%b rd=%b wr=%b, required idle zeros/single pulse",
               $time, bus.i_ack, bus.i_rdata, bus.i_err, bus.d_ack, bus.d_rdata, bus.d_err,
               bus.mem_read, bus.mem_write);
    end
    mon_prev_ack    = bus.i_ack | bus.d_ack;
    mon_prev_strobe = mon_strobe;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  task automatic drive_fetch(input logic [31:0] addr, input int stall);
    logic got;
    wait_idle();
    stall_plan = stall;
    bus.i_req  = 1'b1;
    bus.i_addr = addr;
    exp_q.push_back(model_txn(1'b0, 1'b0, addr, 32'h0, 4'h0, stall));
    model_last_d = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (c == 0) bus.i_addr = $urandom;  // granted already; must be ignored
      if (bus.i_ack) begin got = 1'b1; break; end
    end
    bus.i_req = 1'b0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL fetch_ack_timeout: no i_ack within 64 cycles, required one");
    end
  endtask

  task automatic drive_data(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input int stall);
    logic got;
    wait_idle();
    stall_plan   = stall;
    bus.d_req    = 1'b1;
    bus.d_write  = wr;
    bus.d_addr   = addr;
    bus.d_wdata  = wdata;
    bus.d_byteen = be;
    exp_q.push_back(model_txn(1'b1, wr, addr, wdata, be, stall));
    model_last_d = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.d_addr   = $urandom;
        bus.d_wdata  = $urandom;
        bus.d_byteen = 4'($urandom_range(0, 15));
        bus.d_write  = 1'($urandom_range(0, 1));
      end
      if (bus.d_ack) begin got = 1'b1; break; end
    end
    bus.d_req = 1'b0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL data_ack_timeout: no d_ack within 64 cycles, required one");
    end
  endtask

  task automatic drive_both(input logic [31:0] iaddr, input logic wr, input logic [31:0] daddr,
                            input logic [31:0] wdata, input logic [3:0] be, input int stall);
    logic got_i, got_d, fetch_first;
    wait_idle();
    stall_plan   = stall;
    bus.i_req    = 1'b1;
    bus.i_addr   = iaddr;
    bus.d_req    = 1'b1;
    bus.d_write  = wr;
    bus.d_addr   = daddr;
    bus.d_wdata  = wdata;
    bus.d_byteen = be;
    fetch_first  = model_last_d;
    if (fetch_first) begin
      exp_q.push_back(model_txn(1'b0, 1'b0, iaddr, 32'h0, 4'h0, stall));
      exp_q.push_back(model_txn(1'b1, wr, daddr, wdata, be, stall));
    end else begin
      exp_q.push_back(model_txn(1'b1, wr, daddr, wdata, be, stall));
      exp_q.push_back(model_txn(1'b0, 1'b0, iaddr, 32'h0, 4'h0, stall));
    end
    model_last_d = fetch_first;  // the second grant is the opposite of the first
    got_i = 1'b0;
    got_d = 1'b0;
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      if (bus.i_ack) begin got_i = 1'b1; bus.i_req = 1'b0; end
      if (bus.d_ack) begin got_d = 1'b1; bus.d_req = 1'b0; end
      if (got_i && got_d) break;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    if (!(got_i && got_d)) begin
      n_vec++; n_err++;
      $display("FAIL both_ack_timeout: got_i=%b got_d=%b, required both 1", got_i, got_d);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_vec++;
    if ({bus.mem_read, bus.mem_write, busy, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err,
         bus.mem_address, bus.mem_writedata, bus.mem_byteenable, bus.i_rdata, bus.d_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rd=%b wr=%b busy=%b addr=%h, required all zero",
               bus.mem_read, bus.mem_write, busy, bus.mem_address);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.mem_read, busy, bus.i_ack, bus.d_ack} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_hold: rd=%b busy=%b, required 0", bus.mem_read, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_release: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_contention();
    int acks;
    txn_t e;
    logic who;
    wait_idle();
    stall_plan   = 1;
    bus.i_req    = 1'b1;
    bus.i_addr   = 32'h0000_1000;
    bus.d_req    = 1'b1;
    bus.d_write  = 1'b0;
    bus.d_addr   = 32'h0000_2000;
    bus.d_byteen = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      who = !model_last_d;
      e = model_txn(who, 1'b0, who ? 32'h0000_2000 : 32'h0000_1000, 32'h0, 4'b1100, 1);
      exp_q.push_back(e);
      model_last_d = who;
    end
    acks = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) acks++;
      if (acks == 4) break;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    n_vec++;
    if (acks != 4) begin
      n_err++;
      $display("FAIL contention_count: acks=%0d, required 4", acks);
    end
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [TW-1:0] ev, ov;
      ev = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL contention_txn: missing completion, required %h", ev);
      end else begin
        ov = obs_q.pop_front();
        if (ov !== ev) begin n_err++; $display("FAIL contention_txn: got %h required %h", ov, ev); end
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL contention_extra: %0d extra completions, required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_single_fetch();
    wait_idle();
    use_fixed  = 1'b1;
    fixed_rd   = 32'hDEAD_BEEF;
    stall_plan = 0;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0040;
    exp_q.push_back(model_txn(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0));
    model_last_d = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_byteenable, bus.i_ack} !==
        {1'b1, 1'b0, 32'h0000_0040, 4'hF, 1'b0}) begin
      n_err++;
      $display("FAIL fetch_issue: rd=%b wr=%b addr=%h be=%h ack=%b, required 1 0 00000040 f 0",
               bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_byteenable, bus.i_ack);
    end
    @(negedge clk);
    bus.i_req = 1'b0;
    n_vec++;
    if ({bus.i_ack, bus.i_err, bus.i_rdata, bus.mem_read} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0}) begin
      n_err++;
      $display("FAIL fetch_resp: ack=%b err=%b rdata=%h rd=%b, required 1 0 deadbeef 0",
               bus.i_ack, bus.i_err, bus.i_rdata, bus.mem_read);
    end
    @(negedge clk);
    n_vec++;
    if ({bus.i_ack, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL fetch_idle: ack=%b busy=%b, required 0 0", bus.i_ack, busy);
    end
    use_fixed = 1'b0;
    while (exp_q.size() > 0) begin
      logic [TW-1:0] ev, ov;
      ev = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL fetch_txn: missing completion, required %h", ev);
      end else begin
        ov = obs_q.pop_front();
        if (ov !== ev) begin n_err++; $display("FAIL fetch_txn: got %h required %h", ov, ev); end
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL fetch_extra: %0d extra completions, required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_store_stall();
    drive_data(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 3);
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [TW-1:0] ev, ov;
      ev = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL store_txn: missing completion, required %h", ev);
      end else begin
        ov = obs_q.pop_front();
        if (ov !== ev) begin n_err++; $display("FAIL store_txn: got %h required %h", ov, ev); end
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL store_extra: %0d extra completions, required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_timeout();
    drive_data(1'b0, 32'h0000_0300, 32'h0, 4'b1111, 1000);
    @(negedge clk);
    n_vec++;
    if ({busy, bus.mem_read, bus.d_ack} !== 3'b000) begin
      n_err++;
      $display("FAIL timeout_idle: busy=%b rd=%b ack=%b, required 0 0 0", busy, bus.mem_read, bus.d_ack);
    end
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [TW-1:0] ev, ov;
      ev = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL timeout_txn: missing completion, required %h", ev);
      end else begin
        ov = obs_q.pop_front();
        if (ov !== ev) begin n_err++; $display("FAIL timeout_txn: got %h required %h", ov, ev); end
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL timeout_extra: %0d extra completions, required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_addr_hold();
    wait_idle();
    stall_plan   = 2;
    bus.d_req    = 1'b1;
    bus.d_write  = 1'b0;
    bus.d_addr   = 32'h0000_0200;
    bus.d_byteen = 4'b0110;
    exp_q.push_back(model_txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'b0110, 2));
    model_last_d = 1'b1;
    @(negedge clk);
    bus.d_addr = 32'h0000_0300;
    @(negedge clk);
    n_vec++;
    if ({bus.mem_read, bus.mem_address} !== {1'b1, 32'h0000_0200}) begin
      n_err++;
      $display("FAIL addr_hold: rd=%b addr=%h, required 1 00000200", bus.mem_read, bus.mem_address);
    end
    for (int c = 0; c < 16; c++) begin
      if (bus.d_ack) break;
      @(negedge clk);
    end
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [TW-1:0] ev, ov;
      ev = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL addr_hold_txn: missing completion, required %h", ev);
      end else begin
        ov = obs_q.pop_front();
        if (ov !== ev) begin n_err++; $display("FAIL addr_hold_txn: got %h required %h", ov, ev); end
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL addr_hold_extra: %0d extra completions, required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_random();
    int mode, stall;
    logic [31:0] a1, a2, wd;
    logic [3:0] be;
    logic wr;
    for (int it = 0; it < 24; it++) begin
      mode  = $urandom_range(0, 2);
      stall = $urandom_range(0, 6);
      a1    = $urandom;
      a2    = $urandom;
      wd    = $urandom;
      be    = 4'($urandom_range(0, 15));
      wr    = 1'($urandom_range(0, 1));
      case (mode)
        0:       drive_fetch(a1, stall);
        1:       drive_data(wr, a2, wd, be, stall);
        default: drive_both(a1, wr, a2, wd, be, stall);
      endcase
    end
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [TW-1:0] ev, ov;
      ev = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL random_txn: missing completion, required %h", ev);
      end else begin
        ov = obs_q.pop_front();
        if (ov !== ev) begin n_err++; $display("FAIL random_txn: got %h required %h", ov, ev); end
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL random_extra: %0d extra completions, required 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_reset_mid_issue();
    wait_idle();
    stall_plan = 1000;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0A00;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({bus.mem_read, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_mid_pre: rd=%b busy=%b, required 1 1", bus.mem_read, busy);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if ({bus.mem_read, bus.mem_write, busy, bus.i_ack, bus.mem_address} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_async: rd=%b wr=%b busy=%b ack=%b addr=%h, required all zero",
               bus.mem_read, bus.mem_write, busy, bus.i_ack, bus.mem_address);
    end
    model_last_d = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_mid_no_ack: %0d completions, required 0", obs_q.size());
      obs_q.delete();
    end
    stall_plan = 0;
    bus.i_addr = 32'h0000_0B00;
    reset      = 1'b1;
    exp_q.push_back(model_txn(1'b0, 1'b0, 32'h0000_0B00, 32'h0, 4'h0, 0));
    model_last_d = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.mem_read, bus.mem_address} !== {1'b1, 32'h0000_0B00}) begin
      n_err++;
      $display("FAIL reset_first_grant: rd=%b addr=%h, required 1 00000b00", bus.mem_read, bus.mem_address);
    end
    @(negedge clk);
    bus.i_req = 1'b0;
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [TW-1:0] ev, ov;
      ev = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL reset_mid_txn: missing completion, required %h", ev);
      end else begin
        ov = obs_q.pop_front();
        if (ov !== ev) begin n_err++; $display("FAIL reset_mid_txn: got %h required %h", ov, ev); end
      end
    end
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL reset_mid_extra: %0d extra completions, required 0", obs_q.size()); obs_q.delete(); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset        = 1'b0;
    bus.i_req    = 1'b0;
    bus.i_addr   = '0;
    bus.d_req    = 1'b0;
    bus.d_write  = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
    bus.d_byteen = '0;
    bus.mem_waitrequest = 1'b0;
    bus.mem_readdata    = '0;

    test_reset();
    test_contention();
    test_single_fetch();
    test_store_stall();
    test_timeout();
    test_addr_hold();
    test_random();
    test_reset_mid_issue();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
